// File: rtl/stp_rx_pkg.sv
// Shared types and defaults for the serial-to-parallel receive controller.
package stp_rx_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } rx_state_t;

    localparam int NUM_BITS_DEF = 24;
    localparam int CNT_W_DEF    = 5;
endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage input synchronizer; channel edge_i also gets a rising-edge pulse.
module sync_edge_det #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             edge_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             rise_o,
    output logic [WIDTH-1:0] data_o
);
    logic [STAGES-1:0][WIDTH:0] pipe_q;
    logic                       edge_dly_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pipe_q     <= '0;
            edge_dly_q <= 1'b0;
        end else begin
            pipe_q[0] <= {data_i, edge_i};
            for (int i = 1; i < STAGES; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            edge_dly_q <= pipe_q[STAGES-1][0];
        end
    end

    assign rise_o = pipe_q[STAGES-1][0] & ~edge_dly_q;
    assign data_o = pipe_q[STAGES-1][WIDTH:1];
endmodule

// File: rtl/stp_rx_ctrl.sv
// Sequences an external LSB-first shift register from a synchronized
// bit clock and hands completed words out over a valid/ready port.
module stp_rx_ctrl
    import stp_rx_pkg::*;
#(
    parameter int NUM_BITS    = NUM_BITS_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                enable,
    input  logic                sclk,
    input  logic                fsync,
    input  logic                sdata,
    output logic                serial_sync,
    output logic                shift_enable,
    input  logic [NUM_BITS-1:0] sr_data,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    input  logic                clear_err,
    output logic                overrun_err,
    output logic                framing_err
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BITS - 1);

    rx_state_t           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_BITS-1:0] rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                ovr_q, ovr_d;
    logic                fe_q, fe_d;
    logic                sclk_rise, fsync_sync;
    logic                load, set_fe;

    sync_edge_det #(
        .STAGES(SYNC_STAGES),
        .WIDTH (2)
    ) u_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .edge_i(sclk),
        .data_i({sdata, fsync}),
        .rise_o(sclk_rise),
        .data_o({serial_sync, fsync_sync})
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_enable = 1'b0;
        load         = 1'b0;
        set_fe       = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sclk_rise && fsync_sync) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        if (fsync_sync) begin
                            // Mid-word fsync resyncs; at bit 0 it is a long fsync.
                            cnt_d  = '0;
                            set_fe = (cnt_q != '0);
                        end else begin
                            shift_enable = 1'b1;
                            if (cnt_q == LAST) begin
                                state_d = LOAD;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                LOAD: begin
                    load    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rx_data_d  = load ? sr_data : rx_data_q;
        rx_valid_d = load | (rx_valid_q & ~rx_ready);
        ovr_d      = (ovr_q & ~clear_err) | (load & rx_valid_q & ~rx_ready);
        fe_d       = (fe_q & ~clear_err) | set_fe;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
            fe_q       <= fe_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign overrun_err = ovr_q;
    assign framing_err = fe_q;
endmodule

// File: tb/tb_stp_rx_ctrl.sv
// Scoreboard bench for stp_rx_ctrl with a behavioural LSB-first shift register.
module tb_stp_rx_ctrl;
    logic        clk, n_rst, enable, sclk, fsync, sdata;
    logic        serial_sync, shift_enable;
    logic [23:0] sr_data, rx_data;
    logic        rx_valid, rx_ready, clear_err;
    logic        overrun_err, framing_err;

    int          checks   = 0;
    int          failures = 0;
    int          shifts   = 0;
    bit          b2b      = 1'b0;
    bit          prev_se  = 1'b0;
    bit          prev_v   = 1'b0;
    logic [23:0] prev_d   = '0;
    logic [23:0] exp_q[$];

    stp_rx_ctrl dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .enable      (enable),
        .sclk        (sclk),
        .fsync       (fsync),
        .sdata       (sdata),
        .serial_sync (serial_sync),
        .shift_enable(shift_enable),
        .sr_data     (sr_data),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .clear_err   (clear_err),
        .overrun_err (overrun_err),
        .framing_err (framing_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) sr_data <= '0;
        else if (shift_enable) sr_data <= {serial_sync, sr_data[23:1]};
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a new word is presented.
    initial begin
        forever begin
            @(negedge clk);
            if (shift_enable) shifts++;
            if (shift_enable && prev_se) b2b = 1'b1;
            prev_se = shift_enable;
            if (!n_rst) begin
                prev_v = 1'b0;
            end else begin
                if (rx_valid && (!prev_v || rx_data !== prev_d)) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word actual=%h required=none",
                                 rx_data);
                    end else begin
                        check("word", {8'h0, rx_data}, {8'h0, exp_q.pop_front()});
                    end
                end
                prev_v = rx_valid;
                prev_d = rx_data;
            end
        end
    end

    // One sclk period = 8 clk; data and fsync change while sclk is low.
    task automatic send_bit(input logic b, input logic fs);
        sdata = b;
        fsync = fs;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_word(input logic [23:0] w);
        send_bit(1'b0, 1'b1);
        for (int i = 0; i < 24; i++) send_bit(w[i], 1'b0);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("word_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic accept();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    int base;

    initial begin
        n_rst = 1'b0;
        enable = 1'b1;
        sclk = 1'b0;
        fsync = 1'b0;
        sdata = 1'b0;
        rx_ready = 1'b0;
        clear_err = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_ovr", overrun_err, 0);
        check("rst_fe", framing_err, 0);
        check("rst_se", shift_enable, 0);
        check("rst_ss", serial_sync, 0);
        n_rst = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_shifts", shifts, 0);
        check("idle_valid", rx_valid, 0);

        base = shifts;
        exp_q.push_back(24'hA5C3F0);
        send_word(24'hA5C3F0);
        drain();
        check("a5_shifts", shifts - base, 24);
        check("a5_valid", rx_valid, 1);
        check("a5_data", rx_data, 24'hA5C3F0);
        check("a5_ovr", overrun_err, 0);
        check("a5_fe", framing_err, 0);
        accept();
        check("a5_accepted", rx_valid, 0);

        exp_q.push_back(24'h000001);
        exp_q.push_back(24'hFFFFFE);
        send_word(24'h000001);
        send_word(24'hFFFFFE);
        drain();
        check("ovr_data", rx_data, 24'hFFFFFE);
        check("ovr_set", overrun_err, 1);
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("ovr_clear", overrun_err, 0);
        accept();

        base = shifts;
        send_bit(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) send_bit(i[0], 1'b0);
        exp_q.push_back(24'h123456);
        send_word(24'h123456);
        drain();
        check("fe_set", framing_err, 1);
        check("fe_data", rx_data, 24'h123456);
        check("fe_shifts", shifts - base, 34);
        accept();

        exp_q.push_back(24'h111111);
        send_word(24'h111111);
        drain();
        exp_q.push_back(24'h222222);
        fork
            send_word(24'h222222);
            begin
                int n = 0;
                int t = 0;
                while (n < 24 && t < 3000) begin
                    @(negedge clk);
                    t++;
                    if (shift_enable) n++;
                end
                check("load_found", n, 24);
                @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        drain();
        check("ld_acc_valid", rx_valid, 1);
        check("ld_acc_data", rx_data, 24'h222222);
        check("ld_acc_ovr", overrun_err, 0);

        send_bit(1'b0, 1'b1);
        for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b0);
        n_rst = 1'b0;
        #1;
        check("mrst_valid", rx_valid, 0);
        check("mrst_data", rx_data, 0);
        check("mrst_fe", framing_err, 0);
        check("mrst_ss", serial_sync, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        base = shifts;
        for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("nofs_shifts", shifts - base, 0);
        check("nofs_valid", rx_valid, 0);
        exp_q.push_back(24'h0F0F0F);
        send_word(24'h0F0F0F);
        drain();
        check("f0_data", rx_data, 24'h0F0F0F);
        check("f0_valid", rx_valid, 1);

        check("sb_empty", exp_q.size(), 0);
        check("no_b2b_shift", b2b, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
